// File: rtl/fare_vending_fsm.sv
// ---------------------------------------------------------------------------
// fare_vending_fsm
//
// Ticket machine controller. Bill strobes from the validator build up credit
// toward a configurable fare. Reaching the fare issues a ticket. Cancel, an
// inactivity timeout, or (in the default build) an overpayment returns the
// escrowed bills and reports the refund amount.
//
// Build option: define FARE_CHANGE_EN to build change-making. An overpayment
// then dispenses a ticket and follows it with a one-cycle change pulse that
// carries the change amount. Without the macro, the CHANGE state is not built
// and change_o / changeAmt_o are tied to zero.
//
// Parameters
//   PRICE     fare in dollars (>= 5)
//   CREDIT_W  width of the credit/amount buses (PRICE+19 < 2**CREDIT_W)
//   TIMEOUT   idle cycles in CREDIT before an automatic refund (0 = off)
//
// Ports
//   clock_i      rising-edge clock
//   clear_i      synchronous active-high reset
//   five_i       $5 bill strobe
//   ten_i        $10 bill strobe
//   twenty_i     $20 bill strobe
//   cancel_i     customer abort, refunds all credit
//   ready_o      bills are being accepted (READY or CREDIT)
//   bill_o       transaction in progress (CREDIT)
//   dispense_o   one-cycle pulse, issue one ticket
//   return_o     one-cycle pulse, return escrowed bills
//   change_o     one-cycle pulse, pay out change
//   credit_o     accumulated credit
//   refundAmt_o  amount being returned while return_o=1, else 0
//   changeAmt_o  change being paid while change_o=1, else 0
// ---------------------------------------------------------------------------
module fare_vending_fsm #(
    parameter int PRICE    = 40,
    parameter int CREDIT_W = 8,
    parameter int TIMEOUT  = 1000
) (
    input  logic                clock_i,
    input  logic                clear_i,
    input  logic                five_i,
    input  logic                ten_i,
    input  logic                twenty_i,
    input  logic                cancel_i,
    output logic                ready_o,
    output logic                bill_o,
    output logic                dispense_o,
    output logic                return_o,
    output logic                change_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic [CREDIT_W-1:0] refundAmt_o,
    output logic [CREDIT_W-1:0] changeAmt_o
);

    // The timer only has to reach TIMEOUT-1, because the edge that sees
    // TIMEOUT-1 is the TIMEOUT-th idle edge after the last accepted bill.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLIMIT = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    typedef enum logic [2:0] {
        ST_READY,
        ST_CREDIT,
        ST_DISPENSE,
        ST_RETURN
`ifdef FARE_CHANGE_EN
        , ST_CHANGE
`endif
    } state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] refundAmt_q;
    logic [TW-1:0]       timer_q;
`ifdef FARE_CHANGE_EN
    logic [CREDIT_W-1:0] changeOwed_q;
    logic [CREDIT_W-1:0] changeAmt_q;
`endif

    logic [CREDIT_W-1:0] billAmt;
    logic                billValid;
    logic [CREDIT_W-1:0] newCredit;
    logic                timeoutHit;

    // Bill decode. Only one bill is credited per cycle, with priority
    // Ten > Twenty > Five. The other strobes in that cycle are dropped.
    always_comb begin
        billAmt = '0;
        if (ten_i) begin
            billAmt = CREDIT_W'(10);
        end else if (twenty_i) begin
            billAmt = CREDIT_W'(20);
        end else if (five_i) begin
            billAmt = CREDIT_W'(5);
        end
    end

    assign billValid  = five_i | ten_i | twenty_i;
    assign newCredit  = credit_q + billAmt;
    assign timeoutHit = (TIMEOUT != 0) && (timer_q == TLIMIT);

    // Main controller. Credit holds the amount paid through the DISPENSE or
    // RETURN cycle and is cleared on the way back to READY. The refund and
    // change amounts are loaded only on entry to their pulse state, so each
    // amount output is already zero outside its pulse.
    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            state_q      <= ST_READY;
            credit_q     <= '0;
            refundAmt_q  <= '0;
            timer_q      <= '0;
`ifdef FARE_CHANGE_EN
            changeOwed_q <= '0;
            changeAmt_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_READY, ST_CREDIT: begin
                    if (state_q == ST_CREDIT && cancel_i) begin
                        state_q     <= ST_RETURN;
                        refundAmt_q <= credit_q;
                    end else if (billValid) begin
                        timer_q  <= '0;
                        credit_q <= newCredit;
                        if (newCredit < PRICE_C) begin
                            state_q <= ST_CREDIT;
                        end else if (newCredit == PRICE_C) begin
                            state_q <= ST_DISPENSE;
                        end else begin
`ifdef FARE_CHANGE_EN
                            state_q      <= ST_DISPENSE;
                            changeOwed_q <= newCredit - PRICE_C;
`else
                            state_q     <= ST_RETURN;
                            refundAmt_q <= newCredit;
`endif
                        end
                    end else if (state_q == ST_CREDIT && timeoutHit) begin
                        state_q     <= ST_RETURN;
                        refundAmt_q <= credit_q;
                    end else if (state_q == ST_CREDIT && TIMEOUT != 0) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_DISPENSE: begin
                    credit_q <= '0;
`ifdef FARE_CHANGE_EN
                    if (changeOwed_q != '0) begin
                        state_q      <= ST_CHANGE;
                        changeAmt_q  <= changeOwed_q;
                        changeOwed_q <= '0;
                    end else begin
                        state_q <= ST_READY;
                    end
`else
                    state_q <= ST_READY;
`endif
                end
                ST_RETURN: begin
                    state_q     <= ST_READY;
                    credit_q    <= '0;
                    refundAmt_q <= '0;
                    timer_q     <= '0;
                end
`ifdef FARE_CHANGE_EN
                ST_CHANGE: begin
                    state_q     <= ST_READY;
                    changeAmt_q <= '0;
                end
`endif
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

    assign ready_o     = (state_q == ST_READY) || (state_q == ST_CREDIT);
    assign bill_o      = (state_q == ST_CREDIT);
    assign dispense_o  = (state_q == ST_DISPENSE);
    assign return_o    = (state_q == ST_RETURN);
    assign credit_o    = credit_q;
    assign refundAmt_o = refundAmt_q;
`ifdef FARE_CHANGE_EN
    assign change_o    = (state_q == ST_CHANGE);
    assign changeAmt_o = changeAmt_q;
`else
    assign change_o    = 1'b0;
    assign changeAmt_o = '0;
`endif

endmodule

// File: tb/tb_fare_vending_fsm.sv
// ---------------------------------------------------------------------------
// tb_fare_vending_fsm
//
// Bench for fare_vending_fsm with PRICE=40, CREDIT_W=8 and TIMEOUT=16.
// A transaction-level model predicts the outputs for every cycle: the running
// credit, the idle count, and a queue of the pulse cycles still owed. Directed
// scenarios with literal expected values come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_fare_vending_fsm;

    localparam int PRICE = 40;
    localparam int CW    = 8;
    localparam int TOUT  = 16;

    logic          clock = 1'b0;
    logic          clear, five, ten, twenty, cancel;
    logic          ready, bill, dispense, ret, change;
    logic [CW-1:0] credit, refundAmt, changeAmt;

    int checks = 0;
    int fails  = 0;

    fare_vending_fsm #(.PRICE(PRICE), .CREDIT_W(CW), .TIMEOUT(TOUT)) dut (
        .clock_i    (clock),
        .clear_i    (clear),
        .five_i     (five),
        .ten_i      (ten),
        .twenty_i   (twenty),
        .cancel_i   (cancel),
        .ready_o    (ready),
        .bill_o     (bill),
        .dispense_o (dispense),
        .return_o   (ret),
        .change_o   (change),
        .credit_o   (credit),
        .refundAmt_o(refundAmt),
        .changeAmt_o(changeAmt)
    );

    // Free-running clock with a 10-unit period.
    always #5 clock = ~clock;

    typedef struct packed {
        logic          rdy;
        logic          bil;
        logic          dsp;
        logic          ret;
        logic          chg;
        logic [CW-1:0] cr;
        logic [CW-1:0] refAmt;
        logic [CW-1:0] chAmt;
    } obs_t;

    obs_t expQ[$];
    obs_t cur;
    bit   curBusy    = 1'b0;
    bit   modelValid = 1'b0;
    int   mCredit    = 0;
    int   mIdle      = 0;
    int   d, n;

    // Output while bills are being accepted. Nonzero credit means a
    // transaction is open.
    function automatic obs_t acceptOut(int c);
        obs_t o = '0;
        o.rdy = 1'b1;
        o.bil = (c > 0);
        o.cr  = CW'(c);
        return o;
    endfunction

    function automatic obs_t pulseOut(bit dsp, bit rt, bit chg, int c, int rf, int ch);
        obs_t o = '0;
        o.dsp    = dsp;
        o.ret    = rt;
        o.chg    = chg;
        o.cr     = CW'(c);
        o.refAmt = CW'(rf);
        o.chAmt  = CW'(ch);
        return o;
    endfunction

    // Reference model. At each edge it works out what the customer has paid
    // and what the machine owes, then predicts the outputs for the next cycle.
    always @(posedge clock) begin
        if (clear) begin
            mCredit = 0;
            mIdle   = 0;
            expQ.delete();
            cur        = acceptOut(0);
            curBusy    = 1'b0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (curBusy) begin
                if (expQ.size() > 0) begin
                    cur = expQ.pop_front();
                end else begin
                    cur     = acceptOut(0);
                    curBusy = 1'b0;
                end
            end else begin
                d = ten ? 10 : twenty ? 20 : five ? 5 : 0;
                n = mCredit + d;
                if (mCredit > 0 && cancel) begin
                    cur     = pulseOut(0, 1, 0, mCredit, mCredit, 0);
                    mCredit = 0;
                end else if (d > 0) begin
                    mIdle = 0;
                    if (n < PRICE) begin
                        mCredit = n;
                        cur     = acceptOut(n);
                    end else if (n == PRICE) begin
                        cur     = pulseOut(1, 0, 0, n, 0, 0);
                        mCredit = 0;
                    end else begin
`ifdef FARE_CHANGE_EN
                        cur = pulseOut(1, 0, 0, n, 0, 0);
                        expQ.push_back(pulseOut(0, 0, 1, 0, 0, n - PRICE));
`else
                        cur = pulseOut(0, 1, 0, n, n, 0);
`endif
                        mCredit = 0;
                    end
                end else if (mCredit > 0) begin
                    mIdle++;
                    if (mIdle == TOUT) begin
                        cur     = pulseOut(0, 1, 0, mCredit, mCredit, 0);
                        mCredit = 0;
                        mIdle   = 0;
                    end else begin
                        cur = acceptOut(mCredit);
                    end
                end else begin
                    cur = acceptOut(0);
                end
                curBusy = !cur.rdy;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, made on the
    // falling edge so that the registered outputs have settled.
    always @(negedge clock) begin
        obs_t act;
        if (modelValid) begin
            act = {ready, bill, dispense, ret, change, credit, refundAmt, changeAmt};
            checks++;
            if (act !== cur) begin
                fails++;
                $display("[TB] FAIL cycleCompare at %0t: actual rdy=%b bill=%b dsp=%b ret=%b chg=%b cr=%0d ref=%0d chAmt=%0d, expected rdy=%b bill=%b dsp=%b ret=%b chg=%b cr=%0d ref=%0d chAmt=%0d",
                         $time, act.rdy, act.bil, act.dsp, act.ret, act.chg, act.cr, act.refAmt, act.chAmt,
                         cur.rdy, cur.bil, cur.dsp, cur.ret, cur.chg, cur.cr, cur.refAmt, cur.chAmt);
            end
        end
    end

    // Drive one cycle of inputs at the falling edge, then return just after
    // the rising edge that samples them.
    task automatic applyStimulus(input bit f, input bit t, input bit tw, input bit c, input bit cl);
        @(negedge clock);
        five   = f;
        ten    = t;
        twenty = tw;
        cancel = c;
        clear  = cl;
        @(posedge clock);
        #1;
    endtask

    task automatic idleCycles(input int k);
        for (int i = 0; i < k; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        clear  = 1'b1;
        five   = 1'b0;
        ten    = 1'b0;
        twenty = 1'b0;
        cancel = 1'b0;

        // Reset state
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("resetReady", ready, 1);
        checkOutput("resetCredit", credit, 0);
        checkOutput("resetReturn", ret, 0);
        checkOutput("resetBill", bill, 0);

        // Exact fare: 10 + 10 + 20
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("exactCredit10", credit, 10);
        checkOutput("exactBill", bill, 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("exactCredit20", credit, 20);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("exactDispense", dispense, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("exactDispenseEnd", dispense, 0);
        checkOutput("exactReadyAfter", ready, 1);
        checkOutput("exactCreditAfter", credit, 0);

        // Overpayment: 20 + 10 + 20 = 50
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
`ifdef FARE_CHANGE_EN
        checkOutput("overDispense", dispense, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("overChange", change, 1);
        checkOutput("overChangeAmt", changeAmt, 10);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("overChangeEnd", change, 0);
        checkOutput("overReady", ready, 1);
`else
        checkOutput("overReturn", ret, 1);
        checkOutput("overRefund", refundAmt, 50);
        checkOutput("overChangeTied", change, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("overReady", ready, 1);
        checkOutput("overRefundCleared", refundAmt, 0);
`endif

        // A Cancel beats a Twenty presented in the same cycle
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("cancelReturn", ret, 1);
        checkOutput("cancelRefund", refundAmt, 10);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("cancelCreditAfter", credit, 0);

        // Timeout fires on the 16th idle edge after the Five
        applyStimulus(1, 0, 0, 0, 0);
        idleCycles(15);
        checkOutput("toNotYet", ret, 0);
        checkOutput("toCreditHeld", credit, 5);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("toReturn", ret, 1);
        checkOutput("toRefund", refundAmt, 5);
        applyStimulus(0, 0, 0, 0, 0);

        // A Ten on idle cycle 15 restarts the count
        applyStimulus(1, 0, 0, 0, 0);
        idleCycles(14);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("toRestartCredit", credit, 15);
        checkOutput("toRestartNoReturn", ret, 0);
        idleCycles(15);
        checkOutput("toRestartNotYet", ret, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("toRestartReturn", ret, 1);
        checkOutput("toRestartRefund", refundAmt, 15);
        applyStimulus(0, 0, 0, 0, 0);

        // Clear in mid-transaction: no refund pulse follows
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("clrCredit30", credit, 30);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("clrReady", ready, 1);
        checkOutput("clrCredit", credit, 0);
        checkOutput("clrReturn", ret, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("clrNoLateReturn", ret, 0);

        // Bill priority, and bills dropped during the DISPENSE cycle
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("prioCredit", credit, 10);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("prioTwentyOverFive", credit, 30);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("prioDispense", dispense, 1);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("dropReady", ready, 1);
        checkOutput("dropCredit", credit, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("dropCreditStill", credit, 0);

        // Random traffic. Quiet stretches alternate with busy ones so that
        // timeouts get exercised as well as payments.
        for (int blk = 0; blk < 20; blk++) begin
            int strobePct;
            strobePct = (blk % 3 == 2) ? 3 : 35;
            for (int i = 0; i < 200; i++) begin
                bit f, t, tw, c, cl;
                f  = ($urandom_range(0, 99) < strobePct);
                t  = ($urandom_range(0, 99) < strobePct);
                tw = ($urandom_range(0, 99) < strobePct);
                c  = ($urandom_range(0, 99) < 4);
                cl = ($urandom_range(0, 249) == 0);
                applyStimulus(f, t, tw, c, cl);
            end
        end

        idleCycles(3);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
